mult255_digit_serial: RTL and testbench

Digit-serial 255x255-bit unsigned integer multiplier producing the full 510-bit product for the Curve25519 field-multiply datapath. It sits directly upstream of the combinational mod-p reduction stage (p = 2^255-19): its 510-bit `out` feeds that stage's 510-bit input. It trades area for latency by processing DIGIT bits of operand b per cycle, MSB-digit first, with a start/done handshake.

---
 rtl/mult255_digit_serial.sv | 115 +++++++++++
 tb/tb_mult255_digit_serial.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult255_digit_serial.sv
// ---------------------------------------------------------------------------
// mult255_digit_serial
//   Digit-serial WIDTH x WIDTH unsigned multiplier producing the full
//   2*WIDTH-bit product. Operand b is consumed DIGIT bits per cycle, MSB digit
//   first, using a Horner-style accumulate: acc = (acc << DIGIT) + a*digit.
//   The result feeds the mod-p reduction stage downstream.
//
// Ports
//   clk    in   1         rising-edge clock
//   rst    in   1         asynchronous active-high reset
//   start  in   1         request pulse, sampled only while idle
//   a      in   WIDTH     multiplicand
//   b      in   WIDTH     multiplier
//   busy   out  1         high while an operation is in flight (RUN or DONE)
//   done   out  1         single-cycle pulse, out valid while high
//   out    out  2*WIDTH   product a*b, held until the next result is written
// ---------------------------------------------------------------------------
module mult255_digit_serial #(
   parameter int WIDTH = 255,
   parameter int DIGIT = 15
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   out
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int PW   = WIDTH + DIGIT;   // partial product width
   localparam int RW   = 2 * WIDTH;       // result width

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [RW-1:0]    acc_q, acc_d;
   logic [RW-1:0]    out_q, out_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic [DIGIT-1:0] dig;
   logic [PW-1:0]    pp;
   logic [RW-1:0]    acc_nxt;

   // Current digit is always the top slice; b_q is shifted left each cycle.
   assign dig     = b_q[WIDTH-1 -: DIGIT];
   assign pp      = {{DIGIT{1'b0}}, a_q} * {{WIDTH{1'b0}}, dig};
   assign acc_nxt = (acc_q << DIGIT) + {{(RW-PW){1'b0}}, pp};

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      out_d   = out_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            acc_d = acc_nxt;
            b_d   = b_q << DIGIT;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(NDIG-1)) begin
               // Publish the value being written to acc on this same edge.
               out_d   = acc_nxt;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         out_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         out_q   <= out_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy = (state_q != S_IDLE);
   assign done = (state_q == S_DONE);
   assign out  = out_q;

endmodule

// File: tb/tb_mult255_digit_serial.sv
// ---------------------------------------------------------------------------
// tb_mult255_digit_serial
//   Self-checking bench. Expected products are pushed to a scoreboard queue
//   when a start is issued; a monitor pops and compares on every done pulse.
//   Inputs are driven on the falling edge, outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_mult255_digit_serial;

   localparam int W    = 255;
   localparam int D    = 15;
   localparam int NDIG = W / D;

   logic               clk;
   logic               rst;
   logic               start;
   logic [W-1:0]       a;
   logic [W-1:0]       b;
   logic               busy;
   logic               done;
   logic [2*W-1:0]     out;

   int checks;
   int errors;
   int ndone;
   int cyc;

   logic [2*W-1:0] sb[$];

   mult255_digit_serial #(.WIDTH(W), .DIGIT(D)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .out   (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard monitor: every done pulse must match the oldest pending product.
   always @(negedge clk) begin
      logic [2*W-1:0] exp;
      if (!rst && done) begin
         ndone  = ndone + 1;
         checks = checks + 1;
         if (sb.size() == 0) begin
            errors = errors + 1;
            $display("FAIL sb_unexpected_done: out=%h, required no done pulse", out);
         end else begin
            exp = sb.pop_front();
            if (out !== exp) begin
               errors = errors + 1;
               $display("FAIL sb_product: out=%h required=%h", out, exp);
            end
         end
      end
   end

   function automatic logic [2*W-1:0] golden(input logic [W-1:0] x, input logic [W-1:0] y);
      logic [2*W-1:0] xe, ye;
      xe = {{W{1'b0}}, x};
      ye = {{W{1'b0}}, y};
      return xe * ye;
   endfunction

   function automatic logic [W-1:0] rnd255();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r[W-1:0];
   endfunction

   // Issue one request from idle; returns the cycle stamp of the accept edge E0.
   task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, output int c0);
      a     = x;
      b     = y;
      start = 1'b1;
      sb.push_back(golden(x, y));
      @(negedge clk);
      c0    = cyc;
      start = 1'b0;
   endtask

   // Bounded wait for done at a falling edge; lat = edges past E0.
   task automatic wait_done(input int c0, output int lat, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (done) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      lat = cyc - c0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; a = '0; b = '0;
      #1;
      checks = checks + 1;
      if (busy !== 1'b0 || done !== 1'b0 || out !== '0) begin
         errors = errors + 1;
         $display("FAIL reset_state: busy=%b done=%b out=%h, required 0/0/0", busy, done, out);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_zero_latency();
      int c0, lat, nbusy;
      bit ok;
      issue('0, {W{1'b1}}, c0);
      nbusy = 1;  // E0 already passed with busy expected high from here on
      checks = checks + 1;
      if (busy !== 1'b1) begin
         errors = errors + 1;
         $display("FAIL busy_after_start: busy=%b required 1", busy);
      end
      wait_done(c0, lat, ok);
      checks = checks + 1;
      if (!ok || lat != NDIG) begin
         errors = errors + 1;
         $display("FAIL latency: ok=%0d edges_after_E0=%0d required %0d", ok, lat, NDIG);
      end
      @(negedge clk);
      checks = checks + 1;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors = errors + 1;
         $display("FAIL busy_after_done: busy=%b done=%b required 0/0", busy, done);
      end
      if (nbusy == 0) $display("unreachable");
   endtask

   task automatic test_small();
      int c0, lat;
      bit ok;
      issue(W'(1), W'(1), c0);
      wait_done(c0, lat, ok);
      @(negedge clk);
      checks = checks + 1;
      if (!ok || done !== 1'b0) begin
         errors = errors + 1;
         $display("FAIL done_pulse_1x1: ok=%0d done=%b required single pulse", ok, done);
      end
      issue(W'(3), W'(5), c0);
      wait_done(c0, lat, ok);
      @(negedge clk);
      checks = checks + 1;
      if (!ok || done !== 1'b0) begin
         errors = errors + 1;
         $display("FAIL done_pulse_3x5: ok=%0d done=%b required single pulse", ok, done);
      end
      a = {W{1'b1}}; b = {W{1'b1}};
      for (int i = 0; i < 10; i++) begin
         checks = checks + 1;
         if (out !== (2*W)'(15) || done !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL hold_out cycle %0d: out=%h done=%b required 15/0", i, out, done);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_all_ones();
      int c0, lat;
      bit ok;
      logic [2*W-1:0] exp;
      exp = {(2*W){1'b1}} - ((2*W)'(1) << 256) + (2*W)'(2);
      issue({W{1'b1}}, {W{1'b1}}, c0);
      wait_done(c0, lat, ok);
      checks = checks + 1;
      if (!ok || out !== exp) begin
         errors = errors + 1;
         $display("FAIL all_ones: ok=%0d out=%h required=%h", ok, out, exp);
      end
      @(negedge clk);
   endtask

   task automatic test_p_minus_1();
      int c0, lat;
      bit ok;
      logic [2*W-1:0] exp, p;
      logic [W-1:0] pm1;
      p   = ((2*W)'(1) << 255) - (2*W)'(19);
      pm1 = p[W-1:0] - W'(1);
      exp = {(2*W){1'b1}} - (2*W)'(5) * ((2*W)'(1) << 258) + (2*W)'(401);
      issue(pm1, pm1, c0);
      wait_done(c0, lat, ok);
      checks = checks + 1;
      if (!ok || out !== exp) begin
         errors = errors + 1;
         $display("FAIL p_minus_1_sq: ok=%0d out=%h required=%h", ok, out, exp);
      end
      checks = checks + 1;
      if ((out % p) !== (2*W)'(1)) begin
         errors = errors + 1;
         $display("FAIL p_minus_1_mod: out_mod_p=%h required 1", out % p);
      end
      @(negedge clk);
   endtask

   task automatic test_busy_ignore_and_abort();
      int c0, lat, nd0;
      bit ok;
      issue(W'(7), W'(9), c0);
      while (cyc < c0 + 4) @(negedge clk);
      a = W'(2); b = W'(2); start = 1'b1;   // sampled at E5, must be ignored
      @(negedge clk);
      start = 1'b0;
      wait_done(c0, lat, ok);
      checks = checks + 1;
      if (!ok || out !== (2*W)'(63) || lat != NDIG) begin
         errors = errors + 1;
         $display("FAIL start_while_busy: ok=%0d lat=%0d out=%h required 63", ok, lat, out);
      end
      @(negedge clk);
      checks = checks + 1;
      if (busy !== 1'b0) begin
         errors = errors + 1;
         $display("FAIL extra_op_started: busy=%b required 0", busy);
      end
      nd0 = ndone;
      issue(W'(5), W'(5), c0);
      while (cyc < c0 + 9) @(negedge clk);
      #2 rst = 1'b1;                        // asserted between edges, before E10
      #1;
      checks = checks + 1;
      if (busy !== 1'b0 || done !== 1'b0 || out !== '0) begin
         errors = errors + 1;
         $display("FAIL async_abort: busy=%b done=%b out=%h required 0/0/0", busy, done, out);
      end
      void'(sb.pop_back());
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (25) @(negedge clk);
      checks = checks + 1;
      if (ndone != nd0 || out !== '0 || busy !== 1'b0) begin
         errors = errors + 1;
         $display("FAIL abort_no_done: pulses=%0d out=%h busy=%b required 0 pulses, out 0", ndone - nd0, out, busy);
      end
   endtask

   task automatic test_back_to_back();
      int c0, prev, lat;
      bit ok;
      prev = -1;
      for (int n = 0; n < 1000; n++) begin
         checks = checks + 1;
         if (busy !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL b2b_not_idle op %0d: busy=%b required 0", n, busy);
         end
         issue(rnd255(), rnd255(), c0);
         if (prev >= 0) begin
            checks = checks + 1;
            if (c0 - prev != NDIG + 2) begin
               errors = errors + 1;
               $display("FAIL b2b_interval op %0d: interval=%0d required %0d", n, c0 - prev, NDIG + 2);
            end
         end
         prev = c0;
         wait_done(c0, lat, ok);
         if (!ok) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL b2b_timeout op %0d: no done, required done", n);
         end
         @(negedge clk);   // edge E18 returns to idle
      end
      checks = checks + 1;
      if (sb.size() != 0) begin
         errors = errors + 1;
         $display("FAIL sb_leftover: pending=%0d required 0", sb.size());
      end
   endtask

   initial begin
      checks = 0; errors = 0; ndone = 0; cyc = 0;
      test_reset();
      test_zero_latency();
      test_small();
      test_all_ones();
      test_p_minus_1();
      test_busy_ignore_and_abort();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
